// File: rtl/options_serializer_pkg.sv
// Shared constants for the options serializer: option code words, record
// limits and FSM state encodings.
// Optional build macro: OPT_SERIALIZER_CHECKSUM_EN (adds a trailing XOR checksum word).
package options_serializer_pkg;

    localparam int MAX_DATA_WORDS = 5;
    localparam int WORD_W         = 32;

    // Option code words, identical to the values the options parser decodes
    localparam logic [31:0] OPT_CODE_START = 32'h1;
    localparam logic [31:0] OPT_CODE_END   = 32'h2;
    localparam logic [31:0] OPT_CODE_INFO  = 32'h3;
    localparam logic [31:0] OPT_CODE_DATA  = 32'h5;

    // Serializer FSM states; each non-idle state names the word being presented
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_START = 4'd1;
    localparam logic [3:0] S_INFO  = 4'd2;
    localparam logic [3:0] S_INFOC = 4'd3;
    localparam logic [3:0] S_DATA  = 4'd4;
    localparam logic [3:0] S_DLEN  = 4'd5;
    localparam logic [3:0] S_DCONT = 4'd6;
    localparam logic [3:0] S_END   = 4'd7;
    localparam logic [3:0] S_CSUM  = 4'd8;

endpackage

// File: rtl/options_serializer_if.sv
// Record-in / word-stream-out bus of the options serializer.
// The slave modport is the serializer itself; the master modport is the
// surrounding logic that offers records and drains the word stream.
interface options_serializer_if
    import options_serializer_pkg::*;
#(
    parameter int MAX_DATA = MAX_DATA_WORDS,
    parameter int W        = WORD_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_has_info;
    logic [W-1:0]          in_info;
    logic                  in_has_data;
    logic [2:0]            in_data_len;
    logic [MAX_DATA*W-1:0] in_data;
    logic                  in_has_end;
    logic                  out_valid;
    logic                  out_ready;
    logic [W-1:0]          out_word;
    logic                  out_last;

    modport master (
        output in_valid, in_has_info, in_info, in_has_data, in_data_len, in_data, in_has_end,
        input  in_ready,
        input  out_valid, out_word, out_last,
        output out_ready
    );

    modport slave (
        input  in_valid, in_has_info, in_info, in_has_data, in_data_len, in_data, in_has_end,
        output in_ready,
        output out_valid, out_word, out_last,
        input  out_ready
    );
endinterface

// File: rtl/options_serializer.sv
// Options serializer: takes one option record per handshake and streams it as
// START, [INFO, INFOC], [DATA, DLEN, DCONT...], [END] words for the parser.
// Optional build macro: OPT_SERIALIZER_CHECKSUM_EN appends an XOR checksum word.
module options_serializer
    import options_serializer_pkg::*;
#(
    parameter int MAX_DATA = MAX_DATA_WORDS,
    parameter int W        = WORD_W
)
(
    input  logic                  clk,
    input  logic                  rst,
    options_serializer_if.slave   bus,
    output logic                  o_busy,
    output logic                  o_err_len
);

`ifdef OPT_SERIALIZER_CHECKSUM_EN
    localparam logic [3:0] S_TAIL = S_CSUM;
`else
    localparam logic [3:0] S_TAIL = S_IDLE;
`endif

    logic [3:0]            r_state;
    logic [2:0]            r_idx;
    logic [2:0]            r_len;
    logic [W-1:0]          r_info;
    logic [MAX_DATA*W-1:0] r_data;
    logic                  r_hasInfo;
    logic                  r_hasData;
    logic                  r_hasEnd;
    logic [W-1:0]          r_word;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_busy;
    logic                  r_errLen;

    logic                  w_accept;
    logic                  w_lenBad;
    logic                  w_fire;
    logic                  w_firstLast;
    logic [3:0]            w_next;
    logic [3:0]            w_nextAfter;
    logic [2:0]            w_nextIdx;
    logic [W-1:0]          w_nextWord;
`ifdef OPT_SERIALIZER_CHECKSUM_EN
    logic [W-1:0]          r_csum;
`endif

    // Successor of a word state, skipping options that are disabled in the record
    function automatic logic [3:0] nextOf(input logic [3:0] s, input logic [2:0] idx,
                                          input logic hasInfo, input logic hasData,
                                          input logic hasEnd, input logic [2:0] len);
        logic [3:0] afterData;
        logic [3:0] afterInfo;
        logic [3:0] n;
        afterData = hasEnd  ? S_END  : S_TAIL;
        afterInfo = hasData ? S_DATA : afterData;
        n = S_IDLE;
        case (s)
            S_START: n = hasInfo ? S_INFO : afterInfo;
            S_INFO:  n = S_INFOC;
            S_INFOC: n = afterInfo;
            S_DATA:  n = S_DLEN;
            S_DLEN:  n = (len != 3'd0) ? S_DCONT : afterData;
            S_DCONT: n = (({1'b0, idx} + 4'd1) < {1'b0, len}) ? S_DCONT : afterData;
            S_END:   n = S_TAIL;
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

    assign w_lenBad    = bus.in_has_data && (bus.in_data_len > 3'(MAX_DATA));
    assign w_accept    = bus.in_valid && (r_state == S_IDLE);
    assign w_fire      = r_valid && bus.out_ready;
    assign w_next      = nextOf(r_state, r_idx, r_hasInfo, r_hasData, r_hasEnd, r_len);
    assign w_nextIdx   = (r_state == S_DCONT) ? (r_idx + 3'd1) : 3'd0;
    assign w_nextAfter = nextOf(w_next, w_nextIdx, r_hasInfo, r_hasData, r_hasEnd, r_len);
    assign w_firstLast = (nextOf(S_START, 3'd0, bus.in_has_info, bus.in_has_data,
                                 bus.in_has_end, bus.in_data_len) == S_IDLE);

    // Word to present once the current word has been taken
    always_comb begin
        w_nextWord = '0;
        case (w_next)
            S_START: w_nextWord = W'(OPT_CODE_START);
            S_INFO:  w_nextWord = W'(OPT_CODE_INFO);
            S_INFOC: w_nextWord = r_info;
            S_DATA:  w_nextWord = W'(OPT_CODE_DATA);
            S_DLEN:  w_nextWord = {{(W-3){1'b0}}, r_len};
            S_DCONT: w_nextWord = W'(r_data >> (W * 32'(w_nextIdx)));
            S_END:   w_nextWord = W'(OPT_CODE_END);
`ifdef OPT_SERIALIZER_CHECKSUM_EN
            S_CSUM:  w_nextWord = r_csum ^ r_word;
`endif
            default: w_nextWord = '0;
        endcase
    end

    // Capture the accepted record so the input bus is free while streaming
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_info    <= '0;
            r_data    <= '0;
            r_len     <= '0;
            r_hasInfo <= 1'b0;
            r_hasData <= 1'b0;
            r_hasEnd  <= 1'b0;
        end else if (w_accept && !w_lenBad) begin
            r_info    <= bus.in_info;
            r_data    <= bus.in_data;
            r_len     <= bus.in_data_len;
            r_hasInfo <= bus.in_has_info;
            r_hasData <= bus.in_has_data;
            r_hasEnd  <= bus.in_has_end;
        end
    end

    // Sequence the record words and drive the registered stream outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_word   <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_errLen <= 1'b0;
        end else begin
            r_errLen <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept && w_lenBad) begin
                    r_errLen <= 1'b1;
                end else if (w_accept) begin
                    r_state <= S_START;
                    r_idx   <= '0;
                    r_word  <= W'(OPT_CODE_START);
                    r_valid <= 1'b1;
                    r_last  <= w_firstLast;
                    r_busy  <= 1'b1;
                end
            end else if (w_fire) begin
                r_state <= w_next;
                r_idx   <= w_nextIdx;
                if (w_next == S_IDLE) begin
                    r_word  <= '0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                end else begin
                    r_word  <= w_nextWord;
                    r_last  <= (w_nextAfter == S_IDLE);
                end
            end
        end
    end

`ifdef OPT_SERIALIZER_CHECKSUM_EN
    // Running XOR of every word of the record already handed downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= '0;
        end else if (w_fire) begin
            r_csum <= r_csum ^ r_word;
        end
    end
`endif

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_valid;
    assign bus.out_word  = r_word;
    assign bus.out_last  = r_last;
    assign o_busy        = r_busy;
    assign o_err_len     = r_errLen;

endmodule

// File: tb/tb_options_serializer.sv
// Directed testbench for options_serializer with hand-computed word streams.
// Expected streams gain their checksum word when OPT_SERIALIZER_CHECKSUM_EN is defined.
module tb_options_serializer;
    import options_serializer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic errLen;

    int checkCount = 0;
    int failCount  = 0;
    int bubbles    = 0;

    logic [31:0] expWords[$];
    logic [31:0] gotWords[$];
    logic        gotLast[$];

    options_serializer_if #(.MAX_DATA(MAX_DATA_WORDS), .W(WORD_W)) bus ();

    options_serializer #(.MAX_DATA(MAX_DATA_WORDS), .W(WORD_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .o_busy    (busy),
        .o_err_len (errLen)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Count one comparison and report it when observed differs from expected
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one record at a falling edge and hold it for exactly one rising edge
    task automatic applyStimulus(input logic hasInfo, input logic [31:0] info, input logic hasData,
                                 input logic [2:0] len, input logic [159:0] data, input logic hasEnd);
        int waitCycles = 0;
        while (!bus.in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("in_ready_before_offer", 32'(bus.in_ready), 32'd1);
        bus.in_has_info = hasInfo;
        bus.in_info     = info;
        bus.in_has_data = hasData;
        bus.in_data_len = len;
        bus.in_data     = data;
        bus.in_has_end  = hasEnd;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid    = 1'b0;
    endtask

    // Drain one record using a 16-cycle out_ready pattern, checking hold while stalled
    task automatic collectStream(input logic [15:0] readyPat);
        int          cyc       = 0;
        logic        seenLast  = 1'b0;
        logic        started   = 1'b0;
        logic        prevStall = 1'b0;
        logic [31:0] prevWord  = '0;
        gotWords.delete();
        gotLast.delete();
        bubbles = 0;
        while (!seenLast && cyc < 60) begin
            bus.out_ready = readyPat[cyc % 16];
            if (prevStall) begin
                checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
                checkOutput("hold_word", bus.out_word, prevWord);
            end
            if (bus.out_valid) begin
                started = 1'b1;
                checkOutput("busy_with_word", 32'(busy), 32'd1);
                if (bus.out_ready) begin
                    gotWords.push_back(bus.out_word);
                    gotLast.push_back(bus.out_last);
                    if (bus.out_last) seenLast = 1'b1;
                end
            end else if (started) begin
                bubbles++;
            end
            prevStall = bus.out_valid && !bus.out_ready;
            prevWord  = bus.out_word;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        checkOutput("stream_completed", 32'(seenLast), 32'd1);
        bus.out_ready = 1'b1;
    endtask

    // Compare the drained stream against expWords and check the return to idle
    task automatic compareStream(input string tag);
        int n;
        checkOutput({tag, "_count"}, 32'(gotWords.size()), 32'(expWords.size()));
        n = (gotWords.size() < expWords.size()) ? gotWords.size() : expWords.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_word%0d", tag, i), gotWords[i], expWords[i]);
            checkOutput($sformatf("%s_last%0d", tag, i), 32'(gotLast[i]), 32'(i == expWords.size() - 1));
        end
        checkOutput({tag, "_bubbles"}, 32'(bubbles), 32'd0);
        checkOutput({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
        checkOutput({tag, "_valid_after"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int found;
        bus.in_valid    = 1'b0;
        bus.in_has_info = 1'b0;
        bus.in_info     = '0;
        bus.in_has_data = 1'b0;
        bus.in_data_len = '0;
        bus.in_data     = '0;
        bus.in_has_end  = 1'b0;
        bus.out_ready   = 1'b1;

        // Reset values
        #12;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_word", bus.out_word, 32'd0);
        checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err_len", 32'(errLen), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Full record with every option present
        expWords = '{32'h1, 32'h3, 32'hAAAA, 32'h5, 32'h3, 32'h10, 32'h11, 32'h12, 32'h2};
`ifdef OPT_SERIALIZER_CHECKSUM_EN
        expWords.push_back(32'hAABF);
`endif
        applyStimulus(1'b1, 32'hAAAA, 1'b1, 3'd3, {32'h0, 32'h0, 32'h12, 32'h11, 32'h10}, 1'b1);
        collectStream(16'hFFFF);
        compareStream("full");

        // START-only record
        expWords = '{32'h1};
`ifdef OPT_SERIALIZER_CHECKSUM_EN
        expWords.push_back(32'h1);
`endif
        applyStimulus(1'b0, 32'h0, 1'b0, 3'd0, 160'h0, 1'b0);
        collectStream(16'hFFFF);
        compareStream("minimal");

        // Oversized data length is rejected with a single err_len pulse
        applyStimulus(1'b0, 32'h0, 1'b1, 3'd6, 160'h0, 1'b0);
        checkOutput("lenerr_pulse", 32'(errLen), 32'd1);
        checkOutput("lenerr_no_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("lenerr_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("lenerr_not_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("lenerr_pulse_end", 32'(errLen), 32'd0);
        checkOutput("lenerr_still_no_valid", 32'(bus.out_valid), 32'd0);
        expWords = '{32'h1, 32'h2};
`ifdef OPT_SERIALIZER_CHECKSUM_EN
        expWords.push_back(32'h3);
`endif
        applyStimulus(1'b0, 32'h0, 1'b0, 3'd7, 160'h0, 1'b1);
        collectStream(16'hFFFF);
        compareStream("after_lenerr");

        // Zero-length data under out_ready pattern 1,0,0,1
        expWords = '{32'h1, 32'h5, 32'h0};
`ifdef OPT_SERIALIZER_CHECKSUM_EN
        expWords.push_back(32'h4);
`endif
        applyStimulus(1'b0, 32'h0, 1'b1, 3'd0, 160'h0, 1'b0);
        collectStream(16'h9999);
        compareStream("backpressure");

        // Largest legal data length
        expWords = '{32'h1, 32'h5, 32'h5, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hD4};
`ifdef OPT_SERIALIZER_CHECKSUM_EN
        expWords.push_back(32'hD5);
`endif
        applyStimulus(1'b0, 32'h0, 1'b1, 3'd5, {32'hD4, 32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1'b0);
        collectStream(16'h5A5A);
        compareStream("maxlen");

        // INFO-only record
        expWords = '{32'h1, 32'h3, 32'h4};
`ifdef OPT_SERIALIZER_CHECKSUM_EN
        expWords.push_back(32'h6);
`endif
        applyStimulus(1'b1, 32'h4, 1'b0, 3'd0, 160'h0, 1'b0);
        collectStream(16'hFFFF);
        compareStream("info_only");

        // Reset while the second data word is on the bus
        applyStimulus(1'b1, 32'hAAAA, 1'b1, 3'd3, {32'h0, 32'h0, 32'h12, 32'h11, 32'h10}, 1'b1);
        bus.out_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            if (bus.out_valid && bus.out_word == 32'h11) found = 1;
            else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        checkOutput("midrst_reached_dcont2", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_word", bus.out_word, 32'd0);
        checkOutput("midrst_last", 32'(bus.out_last), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("midrst_no_valid", 32'(bus.out_valid), 32'd0);
        expWords = '{32'h1, 32'h3, 32'h55, 32'h2};
`ifdef OPT_SERIALIZER_CHECKSUM_EN
        expWords.push_back(32'h55);
`endif
        applyStimulus(1'b1, 32'h55, 1'b0, 3'd0, 160'h0, 1'b1);
        collectStream(16'hFFFF);
        compareStream("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/options_serializer.md
Name: options_serializer

Overview:
- Transmit-side counterpart of the options parser.
- Accepts one option record per handshake and serialises it into a 32-bit word stream in the exact encoding the parser consumes: START, [INFO, INFOCONTENTS], [DATA, DATALEN, DATACONTENTS...], [ENDOPTION].
- Sits between the packet-building logic and the link/stream that feeds the parser; output is valid/ready with a last flag.

Parameters:
- MAX_DATA, 5, maximum DATACONTENTS words per record; matches the five-entry data array in global_package.
- W, 32, word width of the record fields and the output stream.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  record offered
- in_ready  out  1  serializer can accept a record
- in_has_info  in  1  emit the INFO option
- in_info  in  W  INFOCONTENTS word
- in_has_data  in  1  emit the DATA option
- in_data_len  in  3  number of DATACONTENTS words, 0..MAX_DATA legal
- in_data  in  MAX_DATA*W  data words; word i at bits [i*W +: W], sent i=0 first
- in_has_end  in  1  emit the ENDOPTION word
- out_valid  out  1  out_word valid
- out_ready  in  1  downstream accepts
- out_word  out  W  stream word
- out_last  out  1  final word of the record
- busy  out  1  record in flight
- err_len  out  1  one-cycle pulse: record rejected because in_data_len > MAX_DATA

Behaviour:
- Reset (async, rst=1):
  - state IDLE; out_valid=0, out_word=0, out_last=0, busy=0, err_len=0.
  - in_ready=1 once rst deasserts.
  - Reset mid-record abandons the record; no partial words are emitted after reset.
- Input handshake:
  - A record is accepted on in_valid & in_ready, and only in IDLE. All input fields are captured into registers.
  - in_ready = (state==IDLE).
- Length check:
  - If in_has_data=1 and in_data_len>MAX_DATA: no words are emitted, err_len pulses for 1 cycle, state stays IDLE, and in_ready stays 1.
  - in_data_len is ignored when in_has_data=0.
- FSM states: IDLE, START, INFO, INFOC, DATA, DLEN, DCONT, END; all outputs registered.
- Latency: the first word (START code) is presented with out_valid=1 the cycle after acceptance.
- Per-word sequence:
  - Each word holds stable until out_valid & out_ready; the next word follows the next cycle with no bubble.
  - START → INFO (if has_info) → INFOC → DATA (if has_data) → DLEN → DCONT × data_len → END (if has_end). Disabled options are skipped.
  - DCONT uses a 3-bit index counter; data_len=0 goes DLEN → next option directly.
- Word encoding (package constants):
  - Option code words: START=32'h1, ENDOPTION=32'h2, INFO=32'h3, DATA=32'h5. These are the codes the parser decodes.
  - INFOC = in_info.
  - DLEN = zero-extended data_len.
  - DCONT = in_data[i].
- out_last:
  - Asserted with the final word of the record.
  - A record with only START sends a single word with out_last=1.
- Completion: after the last handshake, the FSM returns to IDLE and in_ready=1 on the next cycle. This gives one idle bubble between records.
- busy=1 from acceptance through the last handshake.
- Worst-case record length: 1+2+2+MAX_DATA+1 = 11 words, which fits the parser's 15-word buffer.
- out_ready held low: the word and out_valid hold indefinitely; no timeout.

Optional Feature:
- Macro: OPT_SERIALIZER_CHECKSUM_EN.
- When defined:
  - One extra word follows the last option word: the XOR of all preceding words of the record.
  - Only that checksum word carries out_last.
  - Worst case becomes 12 words.
- When undefined: no checksum word; the XOR accumulator logic is absent.

Decomposition:
- global_package gains:
  - localparams OPT_CODE_START, OPT_CODE_END, OPT_CODE_INFO, OPT_CODE_DATA.
  - MAX_DATA_WORDS=5.
  - typedef e_SerStates {S_IDLE, S_START, S_INFO, S_INFOC, S_DATA, S_DLEN, S_DCONT, S_END, S_CSUM}.
- Existing e_options and st_Field are reused by the bench scoreboard.
- Single module; no sub-module. An output register slice is not justified since the outputs are already registered.

Test Plan:
- Full record: has_info=1 info=0xAAAA, has_data=1 len=3 data={0x10,0x11,0x12}, has_end=1, out_ready=1 → words 1,3,0xAAAA,5,3,0x10,0x11,0x12,2 on consecutive cycles; out_last on word 2; in_ready back 1 cycle later.
- Minimal record: all has_*=0 → single word 0x1 with out_last=1; busy high exactly for that transfer.
- Length error: has_data=1 len=6 → no out_valid, err_len=1 for one cycle, in_ready stays 1; then a valid record streams normally.
- Backpressure: data len=0, out_ready toggling 1,0,0,1,... → each word held stable while stalled; sequence 1,5,0 with out_last on 0; no words lost or duplicated.
- Reset mid-record: assert rst during DCONT word 2 → outputs zero immediately; after release in_ready=1 and the next record starts at word 0x1.
- With OPT_SERIALIZER_CHECKSUM_EN: has_info=1 info=0x4, others 0 → words 1,3,4,then 0x6 (1^3^4) with out_last only on 0x6.
